// File: rtl/mem_port_ctrl.sv
// Memory port controller: hands one request at a time from the multicycle
// controller to an external memory. It waits for mem_rdy for up to TIMEOUT
// BUSY cycles, then reports completion (done) or timeout (err).
//
// state | meaning
// IDLE  | waiting for req_valid; request fields are captured on acceptance
// BUSY  | memory request driven, waiting for mem_rdy
// DONE  | one-cycle done pulse, rdata updated on reads
// ERR   | one-cycle err pulse after the timeout, rdata untouched
module mem_port_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       timeout_hit;

    assign accept      = (state == IDLE) && req_valid;
    assign timeout_hit = (wait_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the combinational stall toward the controller.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = req_valid;
                if (mem_rdy) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter: cleared on acceptance, counts BUSY cycles without mem_rdy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (accept) begin
            wait_cnt <= 8'd0;
        end else if ((state == BUSY) && !mem_rdy) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Memory request registers double as the request latch: loaded on
    // acceptance, held through BUSY, cleared whenever BUSY is left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_en    <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
        end else if (!((state == BUSY) && (state_nxt == BUSY))) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end
    end

    // Completion pulses and read-data capture on the edge leaving BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            done <= (state == BUSY) && mem_rdy;
            err  <= (state == BUSY) && !mem_rdy && timeout_hit;
            if ((state == BUSY) && mem_rdy && !mem_we) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl with a transaction-level reference:
// each access is described by its ready delay, from which the expected BUSY
// length, outcome and read data follow arithmetically.
module tb_mem_port_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          done;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdy;
    logic [DW-1:0] mem_rdata;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_rdata;

    mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One access; d = number of BUSY cycles with mem_rdy low before it rises
    // (d >= TO means the memory never answers).
    task automatic do_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int d,
                          input logic [DW-1:0] rdat);
        int  busy_len;
        bit  ok;
        ok       = (d < TO);
        busy_len = ok ? d + 1 : TO;
        @(negedge clk);
        chk("idle_mem_en", mem_en, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_err", err, 1'b0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        mem_rdy   = 1'b0;
        #1;
        chk("idle_stall", stall, 1'b1);
        @(posedge clk);
        for (int k = 0; k < busy_len; k++) begin
            @(negedge clk);
            chk("busy_mem_en", mem_en, 1'b1);
            chk("busy_mem_we", mem_we, we);
            chk("busy_mem_addr", mem_addr, addr);
            chk("busy_mem_wdata", mem_wdata, wdata);
            chk("busy_stall", stall, 1'b1);
            chk("busy_done", done, 1'b0);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_we    = $urandom_range(0, 1);
            mem_rdy   = (k == d);
            mem_rdata = we ? DW'($urandom) : rdat;
            @(posedge clk);
        end
        @(negedge clk);
        if (ok && !we) exp_rdata = rdat;
        chk("out_done", done, ok);
        chk("out_err", err, !ok);
        chk("out_mem_en", mem_en, 1'b0);
        chk("out_stall", stall, 1'b0);
        chk("out_rdata", rdata, exp_rdata);
        req_valid = 1'b0;
        mem_rdy   = $urandom_range(0, 1);
        mem_rdata = $urandom;
        @(posedge clk);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_rdy   = $urandom_range(0, 1);
            mem_rdata = $urandom;
            #1;
            chk("gap_stall", stall, 1'b0);
            chk("gap_mem_en", mem_en, 1'b0);
            chk("gap_done", done, 1'b0);
            chk("gap_err", err, 1'b0);
            @(posedge clk);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        exp_rdata = '0;
        #3;
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases: zero-wait read, 3-wait write, timeout, ready at boundary.
        do_txn(1'b0, 32'h10, 32'h0, 0, 32'h8C020004);
        do_txn(1'b1, 32'h44, 32'h12345678, 3, 32'h0);
        do_txn(1'b0, 32'h50, 32'hA5A5A5A5, 9, 32'hDEADBEEF);
        idle_gap(1);
        do_txn(1'b0, 32'h10, 32'h0, 3, 32'hCAFEF00D);

        // Reset asserted in the second BUSY cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h30;
        mem_rdy   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        exp_rdata = '0;
        chk("midrst_mem_en", mem_en, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_rdata", rdata, '0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_hold_mem_en", mem_en, 1'b0);
        reset_n = 1'b1;
        do_txn(1'b0, 32'h34, 32'h0, 1, 32'h13572468);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                   int'($urandom_range(0, TO + 1)), DW'($urandom));
            idle_gap(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request and memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning read and write data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, range 1-255, meaning maximum BUSY cycles to wait for mem_rdy.
REQ-004 SHALL have port clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  meaning the multicycle controller requests a memory access this cycle.
REQ-007 SHALL have port req_we  input  1  meaning 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  meaning access address selected by the datapath (PC or ALUOut).
REQ-009 SHALL have port req_wdata  input  DATA_W  meaning store data.
REQ-010 SHALL have port stall  output  1  meaning the controller holds its state while this is high.
REQ-011 SHALL have port rdata  output  DATA_W  meaning registered read data, fed to the instruction and data registers.
REQ-012 SHALL have port done  output  1  meaning one-cycle pulse on successful completion.
REQ-013 SHALL have port err  output  1  meaning one-cycle pulse on timeout.
REQ-014 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) meaning the external memory request.
REQ-015 SHALL have ports mem_rdy (input, 1) and mem_rdata (input, DATA_W) meaning external completion and read data.

Function
REQ-016 SHALL implement a four-state FSM with states IDLE, BUSY, DONE and ERR.
REQ-017 In IDLE with req_valid=1, SHALL latch req_we, req_addr and req_wdata, clear the wait counter and enter BUSY on the next edge.
REQ-018 In IDLE with req_valid=0, SHALL remain in IDLE and ignore mem_rdy.
REQ-019 SHALL drive stall combinationally as req_valid AND (state is IDLE or BUSY); stall SHALL be 0 in DONE and ERR.
REQ-020 In BUSY, SHALL register mem_en=1 with mem_we, mem_addr and mem_wdata taken from the latched values; in all other states these outputs SHALL be 0.
REQ-021 Inputs req_* SHALL be ignored while in BUSY, DONE or ERR.
REQ-022 In BUSY with mem_rdy=1, SHALL enter DONE; on a read, mem_rdata SHALL be captured into rdata on the same edge.
REQ-023 On a write, rdata SHALL retain its previous value.
REQ-024 In BUSY with mem_rdy=0, the 8-bit wait counter SHALL increment by 1 each cycle.
REQ-025 When the counter equals TIMEOUT-1 and mem_rdy=0, SHALL enter ERR; if mem_rdy=1 on that same cycle, DONE SHALL take priority.
REQ-026 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-027 In ERR, SHALL assert err=1 for exactly one cycle, leave rdata unchanged, then return to IDLE.
REQ-028 A new request SHALL be accepted only from IDLE; minimum occupancy is 3 cycles (IDLE accept, BUSY, DONE).
REQ-029 With mem_rdy=1 in the first BUSY cycle, stall SHALL fall in the cycle after BUSY, giving 2 stall cycles per access.
REQ-030 mem_rdy SHALL be sampled only in BUSY.

Reset
REQ-031 When reset_n=0, SHALL immediately force state to IDLE and clear the counter, rdata, done, err, mem_en, mem_we, mem_addr and mem_wdata to 0, independent of clk.
REQ-032 Reset asserted mid-BUSY SHALL drop mem_en in the same cycle and discard the transaction.
REQ-033 After reset_n rises, the first request SHALL be accepted on the first rising clk edge with req_valid=1.

Verification
REQ-034 Read, zero wait: req_valid=1, req_we=0, req_addr=0x10, mem_rdy=1 in the first BUSY cycle, mem_rdata=0x8C020004 -> mem_en high for 1 cycle, then done pulse, rdata=0x8C020004, and stall high for 2 cycles.
REQ-035 Write, 3 wait cycles: req_we=1, req_addr=0x44, req_wdata=0x12345678, mem_rdy=1 on the 4th BUSY cycle -> mem_en/mem_we high for 4 cycles, mem_wdata=0x12345678, rdata unchanged, then done pulse.
REQ-036 Timeout: TIMEOUT=4, mem_rdy held 0 -> 4 BUSY cycles, err pulse, done never asserted, stall low in the ERR cycle, then IDLE.
REQ-037 Ready at boundary: TIMEOUT=4, mem_rdy=1 exactly in the 4th BUSY cycle -> DONE, no err.
REQ-038 Request change in BUSY: req_addr changes from 0x10 to 0x20 during BUSY -> mem_addr stays 0x10.
REQ-039 Reset mid-BUSY: reset_n low in the 2nd BUSY cycle -> mem_en=0 immediately, no done/err, and the next request after release is serviced normally.
